// File: rtl/hall_call_dispatcher.sv
`default_nettype none
// ============================================================================
// hall_call_dispatcher: latches hall calls and assigns each to the cheaper of
// two cars, round-robin over pending floors.  Rev 1.0
// ============================================================================
module hall_call_dispatcher (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  simState,
    input  logic [5:0]  FloorsRequested,
    input  logic [7:0]  half_elevatorPositions,
    output logic [11:0] FloorDestinations,
    output logic [5:0]  pending,
    output logic        assign_valid,
    output logic [2:0]  assign_floor,
    output logic        assign_car
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SELECT = 2'd1;
    localparam logic [1:0] SCORE  = 2'd2;
    localparam logic [1:0] ASSIGN = 2'd3;

    localparam logic [2:0] RR_RESET = 3'd5;

    logic [1:0]  state;
    logic [1:0]  state_next;
    logic        do_select;
    logic        do_score;
    logic        do_assign;

    logic        sim_clear;
    logic        sim_run;
    logic [3:0]  pos_left;
    logic [3:0]  pos_right;

    logic [2:0]  rr_ptr;
    logic [2:0]  sel_floor;
    logic [5:0]  cost_left;
    logic [5:0]  cost_right;

    logic [11:0] arrive;
    logic [11:0] dest_kept;
    logic [5:0]  blocked;
    logic [5:0]  new_req;
    logic [2:0]  pick_floor;
    logic        pick_found;
    logic [5:0]  sel_onehot;
    logic        winner;
    logic [5:0]  score_left;
    logic [5:0]  score_right;
    logic [5:0]  pending_next;
    logic [11:0] dest_next;

    function automatic logic [2:0] popcount6(input logic [5:0] v);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < 6; i++) begin
            n = n + {2'b00, v[i]};
        end
        return n;
    endfunction

    function automatic logic [3:0] abs_diff(input logic [3:0] a, input logic [3:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    assign sim_clear = (simState == 2'b00);
    assign sim_run   = (simState == 2'b01);
    assign pos_left  = half_elevatorPositions[3:0];
    assign pos_right = half_elevatorPositions[7:4];

    // Positions 11..15 never equal an even floor position, so they clear nothing.
    for (genvar f = 0; f < 6; f++) begin : g_arrive
        localparam logic [3:0] FLOOR_POS = 4'(2 * f);
        assign arrive[f]     = (pos_left  == FLOOR_POS);
        assign arrive[f + 6] = (pos_right == FLOOR_POS);
    end

    assign dest_kept = FloorDestinations & ~arrive;
    assign blocked   = pending | dest_kept[5:0] | dest_kept[11:6];
    assign new_req   = FloorsRequested & ~blocked;

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next = state;
        if (sim_clear) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    state_next = (sim_run && (pending != 6'd0)) ? SELECT : IDLE;
                SELECT:  state_next = SCORE;
                SCORE:   state_next = ASSIGN;
                ASSIGN:  state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // FSM output decode
    always_comb begin
        do_select = 1'b0;
        do_score  = 1'b0;
        do_assign = 1'b0;
        if (!sim_clear) begin
            case (state)
                SELECT:  do_select = 1'b1;
                SCORE:   do_score  = 1'b1;
                ASSIGN:  do_assign = 1'b1;
                default: ;
            endcase
        end
    end

    // Round-robin search starts one floor above the last assigned floor.
    always_comb begin
        logic [3:0] idx;
        pick_found = 1'b0;
        pick_floor = 3'd0;
        for (int i = 1; i <= 6; i++) begin
            idx = {1'b0, rr_ptr} + 4'(i);
            if (idx >= 4'd6) begin
                idx = idx - 4'd6;
            end
            if (!pick_found && pending[idx[2:0]]) begin
                pick_found = 1'b1;
                pick_floor = idx[2:0];
            end
        end
    end

    always_comb begin
        logic [3:0] target;
        target      = {sel_floor, 1'b0};
        score_left  = {2'b00, abs_diff(pos_left, target)}
                    + {1'b0, popcount6(FloorDestinations[5:0]), 2'b00};
        score_right = {2'b00, abs_diff(pos_right, target)}
                    + {1'b0, popcount6(FloorDestinations[11:6]), 2'b00};
    end

    assign winner     = (cost_right < cost_left);
    assign sel_onehot = 6'd1 << sel_floor;

    always_comb begin
        pending_next = pending | new_req;
        dest_next    = dest_kept;
        if (do_assign) begin
            pending_next = pending_next & ~sel_onehot;
            if (winner) begin
                dest_next = dest_next | {sel_onehot, 6'd0};
            end else begin
                dest_next = dest_next | {6'd0, sel_onehot};
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            FloorDestinations <= 12'd0;
            pending           <= 6'd0;
            assign_valid      <= 1'b0;
            assign_floor      <= 3'd0;
            assign_car        <= 1'b0;
            rr_ptr            <= RR_RESET;
            sel_floor         <= 3'd0;
            cost_left         <= 6'd0;
            cost_right        <= 6'd0;
        end else if (sim_clear) begin
            FloorDestinations <= 12'd0;
            pending           <= 6'd0;
            assign_valid      <= 1'b0;
            assign_floor      <= 3'd0;
            assign_car        <= 1'b0;
            rr_ptr            <= RR_RESET;
            sel_floor         <= 3'd0;
            cost_left         <= 6'd0;
            cost_right        <= 6'd0;
        end else begin
            FloorDestinations <= dest_next;
            pending           <= pending_next;
            assign_valid      <= do_assign;
            if (do_select) begin
                sel_floor <= pick_floor;
            end
            if (do_score) begin
                cost_left  <= score_left;
                cost_right <= score_right;
            end
            if (do_assign) begin
                rr_ptr       <= sel_floor;
                assign_floor <= sel_floor;
                assign_car   <= winner;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hall_call_dispatcher.sv
`default_nettype none
// Testbench for hall_call_dispatcher: table of single dispatches plus
// hand-written multi-cycle sequences, with a scoreboard of expected assignments.
module tb_hall_call_dispatcher;

    logic        clk;
    logic        rst;
    logic [1:0]  simState;
    logic [5:0]  FloorsRequested;
    logic [7:0]  half_elevatorPositions;
    logic [11:0] FloorDestinations;
    logic [5:0]  pending;
    logic        assign_valid;
    logic [2:0]  assign_floor;
    logic        assign_car;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [3:0]  pos_l;
        logic [3:0]  pos_r;
        logic [2:0]  floor;
        logic        car;
        logic [11:0] dest;
    } vec_t;

    typedef struct {
        logic [2:0] floor;
        logic       car;
    } exp_t;

    vec_t table_v[8];
    exp_t sb[$];
    exp_t got;

    hall_call_dispatcher dut (
        .clk                    (clk),
        .rst                    (rst),
        .simState               (simState),
        .FloorsRequested        (FloorsRequested),
        .half_elevatorPositions (half_elevatorPositions),
        .FloorDestinations      (FloorDestinations),
        .pending                (pending),
        .assign_valid           (assign_valid),
        .assign_floor           (assign_floor),
        .assign_car             (assign_car)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_block();
        simState        = 2'b00;
        FloorsRequested = 6'd0;
        tick();
    endtask

    task automatic push_exp(input logic [2:0] f, input logic c);
        exp_t e;
        e.floor = f;
        e.car   = c;
        sb.push_back(e);
    endtask

    // Pulse a request and advance to just after the assigning edge.
    task automatic pulse_dispatch(input logic [5:0] req);
        FloorsRequested = req;
        tick();
        FloorsRequested = 6'd0;
        repeat (4) tick();
    endtask

    always @(negedge clk) begin
        if (assign_valid === 1'b1) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_assign: got floor %0d car %0d, required no pulse",
                         assign_floor, assign_car);
            end else begin
                got = sb.pop_front();
                check("assign_floor", 32'(assign_floor), 32'(got.floor));
                check("assign_car",   32'(assign_car),   32'(got.car));
            end
        end
    end

    initial begin
        table_v[0] = '{4'd0,  4'd10, 3'd4, 1'b1, 12'h400};
        table_v[1] = '{4'd0,  4'd0,  3'd2, 1'b0, 12'h004};
        table_v[2] = '{4'd10, 4'd0,  3'd1, 1'b1, 12'h080};
        table_v[3] = '{4'd3,  4'd5,  3'd2, 1'b0, 12'h004};
        table_v[4] = '{4'd15, 4'd9,  3'd5, 1'b1, 12'h800};
        table_v[5] = '{4'd12, 4'd0,  3'd0, 1'b1, 12'h040};
        table_v[6] = '{4'd7,  4'd7,  3'd3, 1'b0, 12'h008};
        table_v[7] = '{4'd1,  4'd14, 3'd0, 1'b0, 12'h001};

        rst                    = 1'b0;
        simState               = 2'b00;
        FloorsRequested        = 6'd0;
        half_elevatorPositions = 8'd0;
        repeat (3) tick();
        check("reset_dest",    32'(FloorDestinations), 32'h0);
        check("reset_pending", 32'(pending),           32'h0);
        check("reset_valid",   32'(assign_valid),      32'h0);
        check("reset_floor",   32'(assign_floor),      32'h0);
        check("reset_car",     32'(assign_car),        32'h0);
        rst = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            half_elevatorPositions = {table_v[i].pos_r, table_v[i].pos_l};
            clear_block();
            simState        = 2'b01;
            FloorsRequested = 6'd1 << table_v[i].floor;
            push_exp(table_v[i].floor, table_v[i].car);
            tick();
            FloorsRequested = 6'd0;
            check("tbl_pending_latch", 32'(pending), 32'(6'd1 << table_v[i].floor));
            repeat (3) tick();
            check("tbl_no_early_valid", 32'(assign_valid), 32'h0);
            tick();
            check("tbl_valid",   32'(assign_valid),      32'h1);
            check("tbl_dest",    32'(FloorDestinations), 32'(table_v[i].dest));
            check("tbl_pending", 32'(pending),           32'h0);
        end

        // Persistence, duplicate drop, and request coinciding with arrival.
        half_elevatorPositions = 8'h00;
        clear_block();
        simState = 2'b01;
        push_exp(3'd2, 1'b0);
        pulse_dispatch(6'b000100);
        check("persist_set", 32'(FloorDestinations), 32'h004);
        repeat (2) tick();
        check("persist_hold", 32'(FloorDestinations), 32'h004);
        FloorsRequested = 6'b000100;
        tick();
        FloorsRequested = 6'd0;
        check("dup_dropped", 32'(pending), 32'h0);
        half_elevatorPositions = 8'h04;
        push_exp(3'd2, 1'b0);
        FloorsRequested = 6'b000100;
        tick();
        FloorsRequested = 6'd0;
        check("arrival_clear",  32'(FloorDestinations), 32'h000);
        check("req_with_clear", 32'(pending),           32'h04);
        repeat (4) tick();
        check("redispatch_dest", 32'(FloorDestinations), 32'h004);
        tick();
        check("arrival_clear2", 32'(FloorDestinations), 32'h000);

        // Load on the left car pushes the next call to the right car.
        half_elevatorPositions = {4'd10, 4'd1};
        clear_block();
        simState = 2'b01;
        push_exp(3'd0, 1'b0);
        pulse_dispatch(6'b000001);
        push_exp(3'd1, 1'b0);
        pulse_dispatch(6'b000010);
        check("load_left", 32'(FloorDestinations), 32'h003);
        half_elevatorPositions = {4'd1, 4'd1};
        push_exp(3'd5, 1'b1);
        pulse_dispatch(6'b100000);
        check("load_right", 32'(FloorDestinations), 32'h803);
        half_elevatorPositions = {4'd11, 4'd1};
        tick();
        check("no_clear_pos11", 32'(FloorDestinations), 32'h803);

        // Two calls latched together, round-robin from rr_ptr=5.
        half_elevatorPositions = {4'd9, 4'd3};
        clear_block();
        simState = 2'b01;
        push_exp(3'd0, 1'b0);
        push_exp(3'd5, 1'b1);
        FloorsRequested = 6'b100001;
        tick();
        FloorsRequested = 6'd0;
        check("rr_pending", 32'(pending), 32'h21);
        repeat (4) tick();
        check("rr_first_valid",   32'(assign_valid), 32'h1);
        check("rr_first_pending", 32'(pending),      32'h20);
        repeat (3) tick();
        check("rr_gap", 32'(assign_valid), 32'h0);
        tick();
        check("rr_second_valid", 32'(assign_valid),      32'h1);
        check("rr_dest",         32'(FloorDestinations), 32'h801);
        check("rr_pending_done", 32'(pending),           32'h0);

        // Hold lets an in-flight dispatch finish, latches but never starts.
        half_elevatorPositions = 8'h00;
        clear_block();
        simState        = 2'b01;
        FloorsRequested = 6'b000010;
        push_exp(3'd1, 1'b0);
        tick();
        FloorsRequested = 6'd0;
        tick();
        simState = 2'b10;
        repeat (3) tick();
        check("hold_inflight_valid", 32'(assign_valid),      32'h1);
        check("hold_inflight_dest",  32'(FloorDestinations), 32'h002);
        FloorsRequested = 6'b010000;
        tick();
        FloorsRequested = 6'd0;
        repeat (5) tick();
        check("hold_latch", 32'(pending), 32'h10);

        // Hold then run then clear.
        half_elevatorPositions = {4'd10, 4'd0};
        clear_block();
        simState        = 2'b10;
        FloorsRequested = 6'b001000;
        tick();
        FloorsRequested = 6'd0;
        repeat (4) tick();
        check("hold_pending", 32'(pending),      32'h08);
        check("hold_valid",   32'(assign_valid), 32'h0);
        simState = 2'b01;
        push_exp(3'd3, 1'b1);
        repeat (3) tick();
        check("run_no_early", 32'(assign_valid), 32'h0);
        tick();
        check("run_valid", 32'(assign_valid),      32'h1);
        check("run_dest",  32'(FloorDestinations), 32'h200);
        simState = 2'b00;
        tick();
        check("clr_dest",    32'(FloorDestinations), 32'h0);
        check("clr_pending", 32'(pending),           32'h0);
        check("clr_valid",   32'(assign_valid),      32'h0);
        check("clr_floor",   32'(assign_floor),      32'h0);
        check("clr_car",     32'(assign_car),        32'h0);

        // Reset in SCORE aborts the dispatch.
        half_elevatorPositions = 8'h00;
        simState        = 2'b01;
        FloorsRequested = 6'b000100;
        tick();
        FloorsRequested = 6'd0;
        repeat (2) tick();
        rst = 1'b0;
        #1;
        check("async_rst_pending", 32'(pending), 32'h0);
        repeat (2) tick();
        rst = 1'b1;
        repeat (6) tick();
        check("abort_dest",    32'(FloorDestinations), 32'h0);
        check("abort_pending", 32'(pending),           32'h0);
        check("abort_valid",   32'(assign_valid),      32'h0);
        check("abort_floor",   32'(assign_floor),      32'h0);

        check("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
